// File: rtl/joy_pkg.sv
// Shared constants for the joystick conditioning path: bit positions inside a
// 6-bit stick word and the mapping of fire buttons onto af_enable.
package joy_pkg;

  // Bit order of a stick word {fire2,fire1,right,left,down,up}
  localparam int unsigned JB_UP    = 0;
  localparam int unsigned JB_DOWN  = 1;
  localparam int unsigned JB_LEFT  = 2;
  localparam int unsigned JB_RIGHT = 3;
  localparam int unsigned JB_FIRE1 = 4;
  localparam int unsigned JB_FIRE2 = 5;

  localparam int unsigned JOY_BITS = 6;

  // af_enable layout {joy2fire2,joy2fire1,joy1fire2,joy1fire1}
  localparam int unsigned AF_J1_FIRE1 = 0;
  localparam int unsigned AF_J1_FIRE2 = 1;
  localparam int unsigned AF_J2_FIRE1 = 2;
  localparam int unsigned AF_J2_FIRE2 = 3;

  typedef logic [JOY_BITS-1:0] joy_t;

  // True for the two fire buttons of a stick word.
  function automatic bit is_fire(input int unsigned bit_idx);
    return (bit_idx == JB_FIRE1) || (bit_idx == JB_FIRE2);
  endfunction

  // af_enable index for a fire bit of stick 0 (joy1) or 1 (joy2).
  // Non-fire bits map to 0; callers gate them with is_fire().
  function automatic int unsigned af_idx(input int unsigned stick, input int unsigned bit_idx);
    if (!is_fire(bit_idx)) begin
      return 0;
    end
    return stick * 2 + (bit_idx - JB_FIRE1);
  endfunction

endpackage

// File: rtl/joy_debounce_line.sv
// One active-low joystick line: 2-flop synchroniser, tick-based debounce and,
// for fire buttons, an optional autofire square wave. Output is registered.
module joy_debounce_line
  import joy_pkg::*;
#(
  parameter int unsigned DEB_MS     = 4,
  parameter int unsigned AF_HALF_MS = 50,
  parameter bit          HAS_AF     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic af_en,
  input  logic bypass,
  input  logic line_raw,
  output logic line_out
);

  localparam logic [3:0] DebLast = 4'(DEB_MS - 1);
  localparam logic [7:0] AfLast  = 8'(AF_HALF_MS - 1);

  logic       sync1_q;
  logic       sync_q;
  logic       stable_q, stable_d;
  logic [3:0] cnt_q, cnt_d;
  logic       af_act_q;
  logic       af_lvl_q, af_lvl_d;
  logic [7:0] phase_q, phase_d;
  logic       out_q, out_d;
  logic       af_act;

  // Autofire only runs while the debounced level is pressed and it is enabled.
  assign af_act = HAS_AF & af_en & ~stable_q;

  // Debounce: a new level must be seen on DEB_MS consecutive ticks.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      if (sync_q == stable_q) begin
        cnt_d = 4'd0;
      end else if (cnt_q == DebLast) begin
        stable_d = sync_q;
        cnt_d    = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Autofire phase and level; a fresh activation outranks a coincident tick.
  always_comb begin
    phase_d  = phase_q;
    af_lvl_d = af_lvl_q;
    if (af_act) begin
      if (!af_act_q) begin
        phase_d  = 8'd0;
        af_lvl_d = 1'b0;
      end else if (tick) begin
        if (phase_q == AfLast) begin
          phase_d  = 8'd0;
          af_lvl_d = ~af_lvl_q;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
    end else begin
      phase_d  = 8'd0;
      af_lvl_d = 1'b1;
    end
  end

  // Output select: bypass shows the synchronised raw line.
  always_comb begin
    out_d = stable_q;
    if (bypass) begin
      out_d = sync_q;
    end else if (af_act) begin
      out_d = af_lvl_d;
    end
  end

  // State registers; everything released/cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= 4'd0;
      af_act_q <= 1'b0;
      af_lvl_q <= 1'b1;
      phase_q  <= 8'd0;
      out_q    <= 1'b1;
    end else begin
      sync1_q  <= line_raw;
      sync_q   <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      af_act_q <= af_act;
      af_lvl_q <= af_lvl_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end

  assign line_out = out_q;

endmodule

// File: rtl/joy_conditioner.sv
// Joystick conditioner between joydecoder and the core: a shared 1 ms tick
// plus twelve independent sync/debounce/autofire lines.
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int unsigned MASTERCLK  = 28000000,
  parameter int unsigned DEB_MS     = 4,
  parameter int unsigned AF_HALF_MS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] joy1_in,
  input  logic [5:0] joy2_in,
  input  logic [3:0] af_enable,
  input  logic       bypass,
  output logic [5:0] joy1_out,
  output logic [5:0] joy2_out,
  output logic       tick_1ms
);

  localparam int unsigned TICKDIV = MASTERCLK / 1000;
  localparam int unsigned TW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam logic [TW-1:0] TickLast = TW'(TICKDIV - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  // Free-running 0..TICKDIV-1 counter; the strobe marks its last count.
  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (tick_cnt_q == TickLast) begin
      tick_cnt_d = '0;
    end
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_1ms = (tick_cnt_q == TickLast);

  for (genvar i = 0; i < JOY_BITS; i++) begin : g_bit
    localparam bit          IsFire = is_fire(i);
    localparam int unsigned Af1Idx = af_idx(0, i);
    localparam int unsigned Af2Idx = af_idx(1, i);

    joy_debounce_line #(
      .DEB_MS     (DEB_MS),
      .AF_HALF_MS (AF_HALF_MS),
      .HAS_AF     (IsFire)
    ) u_joy1 (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick_1ms),
      .af_en    (IsFire & af_enable[Af1Idx]),
      .bypass   (bypass),
      .line_raw (joy1_in[i]),
      .line_out (joy1_out[i])
    );

    joy_debounce_line #(
      .DEB_MS     (DEB_MS),
      .AF_HALF_MS (AF_HALF_MS),
      .HAS_AF     (IsFire)
    ) u_joy2 (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick_1ms),
      .af_en    (IsFire & af_enable[Af2Idx]),
      .bypass   (bypass),
      .line_raw (joy2_in[i]),
      .line_out (joy2_out[i])
    );
  end

endmodule

// File: doc/joy_conditioner.md
Name: joy_conditioner

Overview:
- Sits between `joydecoder` and the `zxuno` core on the joystick path.
- Takes the 12 raw joystick lines (2 sticks × up/down/left/right/fire1/fire2, active-low) and synchronises and debounces each line.
- Optionally adds autofire on each fire button.
- Presents conditioned active-low lines to the core, so shift-register glitches and contact bounce never reach the Spectrum.

Parameters:
- MASTERCLK, 28000000, system clock frequency in Hz; `TICKDIV = MASTERCLK/1000` (integer).
- DEB_MS, 4, number of consecutive 1 ms ticks a changed level must persist before it is accepted (range 1..15).
- AF_HALF_MS, 50, autofire half-period in ms ticks (range 1..255); 50 gives a 10 Hz fire rate.

Ports:
- clk  in  1  system clock (`sysclk`)
- rst  in  1  synchronous reset, active-high
- joy1_in  in  6  stick 1 raw, active-low, bits {fire2,fire1,right,left,down,up} = [5:0]
- joy2_in  in  6  stick 2 raw, same bit order
- af_enable  in  4  autofire enable {joy2fire2,joy2fire1,joy1fire2,joy1fire1} = [3:0]
- bypass  in  1  1 = skip debounce and autofire (sync only)
- joy1_out  out  6  stick 1 conditioned, active-low, same bit order
- joy2_out  out  6  stick 2 conditioned
- tick_1ms  out  1  one-cycle strobe every TICKDIV clocks (for debug and reuse)

Behaviour:
- **Clock and reset.** One clock, `clk`. Reset is synchronous and active-high on `rst`. All state updates on the rising edge of `clk`.
- **Reset values.**
  - All outputs, sync flops and debounced levels are 1 (released).
  - All counters are 0; `tick_1ms` is 0.
- **Tick generator.**
  - Counter runs 0..TICKDIV-1 and wraps to 0.
  - `tick_1ms` is 1 for exactly the cycle in which the counter equals TICKDIV-1.
  - The first tick after reset occurs on cycle TICKDIV.
- **Synchroniser.** A 2-flop chain per line; `sync` is the second flop.
- **Debounce, per line.** Each line holds a `stable` level and a 4-bit count `cnt`. On each tick:
  - If `sync == stable`: `cnt` <= 0.
  - Else if `cnt == DEB_MS-1`: `stable` <= `sync` and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Between ticks, `stable` and `cnt` hold. Input glitches shorter than a tick period that do not straddle a tick are invisible.
  - A bounce (`sync` returning to `stable` at any tick) restarts the count.
- **Autofire, per fire line.**
  - Active when `af_enable[i] == 1` and the debounced level is 0 (pressed).
  - On the debounced press edge: output asserted (0) on the next clock, and the 8-bit phase counter is cleared.
  - While held: on each tick the phase counter increments. At AF_HALF_MS-1 it wraps to 0 and the output toggles.
  - On the debounced release edge: output is 1 on the next clock, regardless of phase.
  - `af_enable` falling while held: output follows the debounced level (0) on the next clock.
  - `af_enable` rising while held: autofire starts as if on a press edge (output 0, phase cleared).
- **Non-fire lines and disabled fire lines.** Output = debounced level, registered, 1 cycle latency.
- **Latency.** A clean step reaches the output after:
  - 2 sync cycles;
  - DEB_MS ticks (counted from the first tick seeing the new `sync`);
  - 1 output register cycle.
- **Bypass.**
  - `bypass == 1`: `out` = `sync` (registered, 3-cycle total latency).
  - Debounce state keeps running in the background.
  - On return to `bypass == 0`, the output reverts to the debounced or autofire path on the next clock.
- **Simultaneous events.** Tick coinciding with a press edge: the press edge has priority (phase cleared, no toggle that cycle).
- **Reset mid-operation.** Outputs return to 1 on the clock after `rst` is sampled high. All counters clear, including partial debounce counts and autofire phase.

Decomposition:
- **Package `joy_pkg`.** Bit-index constants JB_UP=0, JB_DOWN=1, JB_LEFT=2, JB_RIGHT=3, JB_FIRE1=4, JB_FIRE2=5; the `af_enable` index map.
- **Sub-module `joy_debounce_line`.** Sync, debounce and optional autofire for one line. It takes `tick`, `af_en`, `bypass` and a parameter HAS_AF. It is instantiated 12 times; the top holds the tick generator only.

Test Plan (MASTERCLK=10000 → TICKDIV=10, DEB_MS=4, AF_HALF_MS=3):
1. Reset, then hold all inputs 1 for 100 cycles -> `joy1_out = joy2_out = 6'h3F`; `tick_1ms` pulses at cycles 10, 20, 30…
2. Drive `joy1_in[0]` to 0 cleanly at cycle 5 -> `joy1_out[0]` stays 1 until the 4th tick after sync (cycle 40), then reads 0 at cycle 41; other bits remain 1.
3. Bounce `joy2_in[2]`: 0 for 25 cycles, 1 for 10, then 0 steady -> no output change during the bounce; the output falls only after 4 uninterrupted ticks of the final 0.
4. `af_enable = 4'b0001`, hold `joy1_in[4]` at 0 for 200 cycles -> `joy1_out[4]` goes 0 after debounce, then toggles every 30 cycles (3 ticks). On release it returns to 1 one cycle after the debounced release, with no trailing toggle.
5. `bypass = 1`, pulse `joy1_in[3]` low for 1 cycle -> `joy1_out[3]` shows a 1-cycle low 3 cycles later. With `bypass = 0` the same pulse produces no output change.
6. Assert `rst` for 1 cycle mid-autofire with the output at 0 -> output is 1 on the next cycle, `tick_1ms` restarts its count from 0, and the held fire needs a full debounce again before reasserting.
